// File: rtl/gcm_pkg.sv
// Shared constants and keep-mask helpers for the GCM input path.
package gcm_pkg;

    localparam int BLK_W         = 128;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_BLK = 4;
    localparam int BYTES_W       = 5;

    function automatic logic [2:0] keep_popcount(input logic [3:0] keep);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + {2'b00, keep[i]};
        end
        return cnt;
    endfunction

    // MSB-first contiguous masks only; an all-zero mask counts as contiguous
    function automatic logic keep_contig(input logic [3:0] keep);
        logic ok;
        case (keep)
            4'hF, 4'hE, 4'hC, 4'h8, 4'h0: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] keep_mask(input logic [31:0] data, input logic [3:0] keep);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/gcm_blk_obuf.sv
// Single-entry output register with valid/ready, plus one pending slot that
// absorbs a block completed while the output is still stalled.
module gcm_blk_obuf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] load_data,
    input  logic         load_valid,
    output logic         pend,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] out_data_r;
    logic [W-1:0] pend_data_r;
    logic         out_valid_r;
    logic         pend_r;
    logic         hs_s;

    assign hs_s      = out_valid_r & out_ready;
    assign pend      = pend_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

    // Output/pending register update; a pending block refills the output on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {W{1'b0}};
            pend_data_r <= {W{1'b0}};
            out_valid_r <= 1'b0;
            pend_r      <= 1'b0;
        end else if (pend_r) begin
            if (hs_s) begin
                out_data_r <= pend_data_r;
                pend_r     <= 1'b0;
            end
        end else if (load_valid) begin
            if (!out_valid_r || hs_s) begin
                out_data_r  <= load_data;
                out_valid_r <= 1'b1;
            end else begin
                pend_data_r <= load_data;
                pend_r      <= 1'b1;
            end
        end else if (hs_s) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/gcm_word_packer.sv
// Packs a 32-bit word stream into 128-bit blocks for aes_gcm, zero-padding the
// final block and reporting the message length in bits.
module gcm_word_packer #(
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      s_data_i,
    input  logic [3:0]       s_keep_i,
    input  logic             s_last_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [127:0]     blk_o,
    output logic [4:0]       blk_bytes_o,
    output logic             blk_last_o,
    output logic             blk_valid_o,
    input  logic             blk_ready_i,
    output logic [LEN_W-1:0] msg_bits_o,
    output logic             err_o
);

    import gcm_pkg::*;

    localparam int          CNT_W    = LEN_W - 3;
    localparam int          PAY_W    = BLK_W + BYTES_W + 1 + CNT_W;
    localparam logic [1:0]  LAST_IDX = 2'(WORDS_PER_BLK - 1);

    logic [2:0][WORD_W-1:0] acc_r;
    logic [1:0]             idx_r;
    logic [CNT_W-1:0]       byte_cnt_r;
    logic                   new_msg_r;
    logic                   err_r;
    logic [LEN_W-1:0]       msg_bits_r;

    logic                   accept_s;
    logic                   complete_s;
    logic                   viol_s;
    logic [WORD_W-1:0]      word_s;
    logic [2:0]             pop_s;
    logic [CNT_W-1:0]       cnt_next_s;
    logic [BLK_W-1:0]       blk_s;
    logic [BYTES_W-1:0]     bytes_s;
    logic                   pend_s;
    logic [PAY_W-1:0]       load_s;
    logic [PAY_W-1:0]       out_s;
    logic                   out_hs_s;
    logic [CNT_W-1:0]       out_cnt_s;

    assign s_ready_o  = !pend_s;
    assign accept_s   = s_valid_i & s_ready_o;
    assign complete_s = accept_s & (s_last_i | (idx_r == LAST_IDX));
    assign word_s     = keep_mask(s_data_i, s_keep_i);
    assign pop_s      = keep_popcount(s_keep_i);
    assign cnt_next_s = (new_msg_r ? {CNT_W{1'b0}} : byte_cnt_r) + {{(CNT_W-3){1'b0}}, pop_s};
    assign viol_s     = (!s_last_i && (s_keep_i != 4'hF)) || !keep_contig(s_keep_i) ||
                        (s_last_i && (s_keep_i == 4'h0) && (idx_r == 2'd0));
    assign bytes_s    = {1'b0, idx_r, 2'b00} + {2'b00, pop_s};

    // Assemble block: filled slots below the index, current word at the index, zeros above
    always_comb begin
        blk_s = {BLK_W{1'b0}};
        for (int i = 0; i < 3; i++) begin
            if (i < int'(idx_r)) begin
                blk_s[BLK_W-1-WORD_W*i -: WORD_W] = acc_r[i];
            end else if (i == int'(idx_r)) begin
                blk_s[BLK_W-1-WORD_W*i -: WORD_W] = word_s;
            end else begin
                blk_s[BLK_W-1-WORD_W*i -: WORD_W] = {WORD_W{1'b0}};
            end
        end
        blk_s[WORD_W-1:0] = (idx_r == LAST_IDX) ? word_s : {WORD_W{1'b0}};
    end

    assign load_s = {blk_s, bytes_s, s_last_i, cnt_next_s};

    gcm_blk_obuf #(
        .W (PAY_W)
    ) u_obuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load_s),
        .load_valid (complete_s),
        .pend       (pend_s),
        .out_data   (out_s),
        .out_valid  (blk_valid_o),
        .out_ready  (blk_ready_i)
    );

    assign blk_o       = out_s[PAY_W-1 -: BLK_W];
    assign blk_bytes_o = out_s[CNT_W+1 +: BYTES_W];
    assign blk_last_o  = out_s[CNT_W];
    assign out_cnt_s   = out_s[CNT_W-1:0];
    assign out_hs_s    = blk_valid_o & blk_ready_i;
    assign msg_bits_o  = msg_bits_r;
    assign err_o       = err_r;

    // Accumulator, word index, byte counter, error pulse and reported length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= '0;
            idx_r      <= 2'd0;
            byte_cnt_r <= {CNT_W{1'b0}};
            new_msg_r  <= 1'b1;
            err_r      <= 1'b0;
            msg_bits_r <= {LEN_W{1'b0}};
        end else begin
            err_r <= accept_s & viol_s;
            if (accept_s) begin
                byte_cnt_r <= cnt_next_s;
                new_msg_r  <= s_last_i;
                if (complete_s) begin
                    idx_r <= 2'd0;
                end else begin
                    idx_r <= idx_r + 2'd1;
                    case (idx_r)
                        2'd0:    acc_r[0] <= word_s;
                        2'd1:    acc_r[1] <= word_s;
                        2'd2:    acc_r[2] <= word_s;
                        default: acc_r    <= acc_r;
                    endcase
                end
            end
            if (out_hs_s && blk_last_o) begin
                msg_bits_r <= {out_cnt_s, 3'b000};
            end
        end
    end

endmodule
